mem_port_arbiter: RTL

- Owns the single shared main-memory port and serves two clients: the instruction cache (read-only) and the data cache (read/write).
- Runs the grant state machine and tracks RAM latency.
- Converts BYTE/HALF/WORD stores into byte-enabled RAM beats, splitting a store that crosses a word boundary into two beats.
- Publishes mem_status, which both caches use to stall.

---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_port_arbiter_store_align.sv | 39 +++
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the main-memory port arbiter: status codes, data-request
// commands, store sizes and the grant FSM state encoding.
package mem_port_arbiter_pkg;

    localparam logic [1:0] MEM_RESTING      = 2'd0;
    localparam logic [1:0] MEM_INST_WORKING = 2'd1;
    localparam logic [1:0] MEM_DATA_WORKING = 2'd2;

    localparam logic [1:0] MEM_NOP   = 2'd0;
    localparam logic [1:0] MEM_READ  = 2'd1;
    localparam logic [1:0] MEM_WRITE = 2'd2;

    localparam logic [2:0] BYTE = 3'd0;
    localparam logic [2:0] HALF = 3'd1;
    localparam logic [2:0] WORD = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INST  = 2'd1,
        ST_DATA1 = 2'd2,
        ST_DATA2 = 2'd3
    } arb_state_e;

    function automatic logic [1:0] status_of(arb_state_e s);
        case (s)
            ST_IDLE: return MEM_RESTING;
            ST_INST: return MEM_INST_WORKING;
            default: return MEM_DATA_WORKING;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_store_align.sv
// Store alignment: turns a left-aligned BYTE/HALF/WORD store at a byte offset
// into one or two byte-enabled RAM beats.
module mem_store_align
    import mem_port_arbiter_pkg::*;
#(
    parameter int LEN = 32
) (
    input  logic [1:0]     offset,
    input  logic [2:0]     req_type,
    input  logic [LEN-1:0] wdata,
    output logic [3:0]     be1,
    output logic [3:0]     be2,
    output logic [LEN-1:0] data1,
    output logic [LEN-1:0] data2,
    output logic           needs_second_beat
);

    logic [3:0]       mask;
    logic [7:0]       be_wide;
    logic [2*LEN-1:0] data_wide;

    // Shifting a double-width window lets bytes pushed past offset 3 fall
    // naturally into the low half, which is exactly the second beat.
    always_comb begin
        case (req_type)
            BYTE:    mask = 4'b1000;
            HALF:    mask = 4'b1100;
            default: mask = 4'b1111;
        endcase
        be_wide   = {mask, 4'b0000} >> offset;
        data_wide = {wdata, {LEN{1'b0}}} >> {offset, 3'b000};
        be1       = be_wide[7:4];
        be2       = be_wide[3:0];
        data1     = data_wide[2*LEN-1:LEN];
        data2     = data_wide[LEN-1:0];
        needs_second_beat = |be_wide[3:0];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shared main-memory port arbiter for icache (read) and dcache (read/write).
// Optional MEM_ARB_ROUND_ROBIN_EN: tie-break toward the port not served last.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int LEN         = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic [LEN-1:0]        i_rdata,
    output logic                  i_done,
    input  logic [1:0]            d_req_signal,
    input  logic [ADDR_WIDTH-1:0] d_req_addr,
    input  logic [2:0]            d_req_type,
    input  logic [LEN-1:0]        d_wdata,
    output logic [LEN-1:0]        d_rdata,
    output logic                  d_done,
    output logic [1:0]            mem_status,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [3:0]            ram_be,
    output logic [ADDR_WIDTH-3:0] ram_addr,
    output logic [LEN-1:0]        ram_wdata,
    input  logic [LEN-1:0]        ram_rdata
);

    localparam logic [2:0]            LAT      = 3'(RAM_LATENCY);
    localparam logic [ADDR_WIDTH-3:0] WORD_INC = {{(ADDR_WIDTH-3){1'b0}}, 1'b1};

    arb_state_e            state, state_next;
    logic [2:0]            cnt;
    logic                  split_q;
    logic [3:0]            be2_q;
    logic [LEN-1:0]        data2_q;
    logic [ADDR_WIDTH-3:0] addr2_q;
    logic                  i_elig, d_elig, gnt_i, gnt_d, d_is_write;
    logic [3:0]            al_be1, al_be2;
    logic [LEN-1:0]        al_data1, al_data2;
    logic                  al_need2;
    logic                  unused_i_offset;

    assign unused_i_offset = ^i_req_addr[1:0];
    assign d_is_write      = (d_req_signal == MEM_WRITE);

    mem_store_align #(.LEN(LEN)) u_align (
        .offset            (d_req_addr[1:0]),
        .req_type          (d_req_type),
        .wdata             (d_wdata),
        .be1               (al_be1),
        .be2               (al_be2),
        .data1             (al_data1),
        .data2             (al_data2),
        .needs_second_beat (al_need2)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_inst;

    always_ff @(posedge clk) begin
        if (rst)
            last_inst <= 1'b1;
        else if (state == ST_IDLE && (gnt_i || gnt_d))
            last_inst <= gnt_i;
    end
`endif

    // A port whose done pulse is high this cycle sits out one grant decision.
    always_comb begin
        i_elig = i_req_valid && !i_done;
        d_elig = (d_req_signal == MEM_READ || d_req_signal == MEM_WRITE) && !d_done;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        gnt_d  = d_elig && (!i_elig || last_inst);
`else
        gnt_d  = d_elig;
`endif
        gnt_i  = i_elig && !gnt_d;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (gnt_d) state_next = ST_DATA1;
                      else if (gnt_i) state_next = ST_INST;
            ST_INST:  if (cnt == 3'd0) state_next = ST_IDLE;
            ST_DATA1: if (cnt == 3'd0) state_next = split_q ? ST_DATA2 : ST_IDLE;
            ST_DATA2: if (cnt == 3'd0) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_status <= MEM_RESTING;
            cnt        <= 3'd0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_be     <= 4'b0000;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            split_q    <= 1'b0;
            be2_q      <= 4'b0000;
            data2_q    <= '0;
            addr2_q    <= '0;
        end else begin
            mem_status <= status_of(state_next);
            ram_en     <= 1'b0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            if (cnt != 3'd0) cnt <= cnt - 3'd1;
            case (state)
                ST_IDLE: begin
                    if (gnt_d) begin
                        ram_en    <= 1'b1;
                        ram_we    <= d_is_write;
                        ram_be    <= d_is_write ? al_be1 : 4'b1111;
                        ram_addr  <= d_req_addr[ADDR_WIDTH-1:2];
                        ram_wdata <= d_is_write ? al_data1 : '0;
                        split_q   <= d_is_write && al_need2;
                        be2_q     <= al_be2;
                        data2_q   <= al_data2;
                        addr2_q   <= d_req_addr[ADDR_WIDTH-1:2] + WORD_INC;
                        cnt       <= LAT;
                    end else if (gnt_i) begin
                        ram_en    <= 1'b1;
                        ram_we    <= 1'b0;
                        ram_be    <= 4'b1111;
                        ram_addr  <= i_req_addr[ADDR_WIDTH-1:2];
                        ram_wdata <= '0;
                        cnt       <= LAT;
                    end
                end
                ST_INST: if (cnt == 3'd0) begin
                    i_rdata <= ram_rdata;
                    i_done  <= 1'b1;
                end
                ST_DATA1: if (cnt == 3'd0) begin
                    if (split_q) begin
                        ram_en    <= 1'b1;
                        ram_we    <= 1'b1;
                        ram_be    <= be2_q;
                        ram_addr  <= addr2_q;
                        ram_wdata <= data2_q;
                        cnt       <= LAT;
                    end else begin
                        d_done <= 1'b1;
                        if (!ram_we) d_rdata <= ram_rdata;
                    end
                end
                ST_DATA2: if (cnt == 3'd0) d_done <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
